// File: rtl/interrupt_arb_pkg.sv
// Shared definitions for the interrupt arbiter: FSM state encodings,
// default parameter values and the source-object width.
package interrupt_arb_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_CTXW    = 9;
    localparam int DEF_TMO_W   = 24;
    localparam int OBJ_W       = 64;

    // One-hot state encoding: each state is a single register bit.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_REQ   = 3'b010,
        ST_DRAIN = 3'b100
    } arb_state_e;

endpackage

// File: rtl/int_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request bit
// at or after rr_ptr, wrapping from N-1 back to 0.
module int_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    typedef logic [IW:0] wide_t;

    // Scan candidates in rotated order; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            wide_t cand;
            cand = wide_t'(rr_ptr) + wide_t'(i);
            if (cand >= wide_t'(N)) begin
                cand = cand - wide_t'(N);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Round-robin arbiter sharing one interrupt engine among NUM_SRC requesters.
// Drives the engine's level interrupt/interrupt_ack handshake and returns a
// one-cycle acknowledge pulse to the granted requester.
// Optional feature: define INT_ARB_WATCHDOG_EN to build the sticky
// handshake watchdog (timeout_flag); otherwise timeout_flag is tied low.
module interrupt_arbiter
    import interrupt_arb_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int CTXW    = DEF_CTXW,
    parameter int TMO_W   = DEF_TMO_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_SRC-1:0]       src_req,
    input  logic [NUM_SRC*OBJ_W-1:0] src_obj,
    input  logic [NUM_SRC*CTXW-1:0]  src_ctx,
    output logic [NUM_SRC-1:0]       src_ack,
    output logic                     int_req,
    output logic [OBJ_W-1:0]         int_obj,
    output logic [CTXW-1:0]          int_ctx,
    input  logic                     int_ack,
    output logic                     busy,
    output logic                     timeout_flag,
    input  logic                     timeout_clr
);

    localparam int IW = $clog2(NUM_SRC);
    typedef logic [IW-1:0] idx_t;

    arb_state_e           state_q, state_d;
    idx_t                 rr_ptr_q, grant_q, pick_idx;
    logic                 pick_valid, load_grant, complete;
    logic [OBJ_W-1:0]     sel_obj, int_obj_q;
    logic [CTXW-1:0]      sel_ctx, int_ctx_q;
    logic [NUM_SRC-1:0]   ack_onehot, src_ack_q;
    logic                 int_req_q;

    int_rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req    (src_req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Mux the winner's object/context and decode the held grant to one-hot.
    always_comb begin
        sel_obj    = '0;
        sel_ctx    = '0;
        ack_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_t'(i) == pick_idx) begin
                sel_obj = src_obj[i*OBJ_W +: OBJ_W];
                sel_ctx = src_ctx[i*CTXW +: CTXW];
            end
            ack_onehot[i] = (idx_t'(i) == grant_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
            state_q <= state_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for ack in REQ, wait for ack release in DRAIN.
    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        complete   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    load_grant = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    complete = 1'b1;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!int_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant capture, engine request, completion pulse and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            int_obj_q <= '0;
            int_ctx_q <= '0;
            int_req_q <= 1'b0;
            src_ack_q <= '0;
        end else begin
            src_ack_q <= '0;
            if (load_grant) begin
                grant_q   <= pick_idx;
                int_obj_q <= sel_obj;
                int_ctx_q <= sel_ctx;
                int_req_q <= 1'b1;
            end
            if (complete) begin
                int_req_q <= 1'b0;
                src_ack_q <= ack_onehot;
                rr_ptr_q  <= (grant_q == idx_t'(NUM_SRC - 1)) ? '0 : grant_q + idx_t'(1);
            end
        end
    end

    assign int_req = int_req_q;
    assign int_obj = int_obj_q;
    assign int_ctx = int_ctx_q;
    assign src_ack = src_ack_q;
    assign busy    = (state_q != ST_IDLE);

`ifdef INT_ARB_WATCHDOG_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_set, tmo_flag_q;

    // Watchdog count: cleared on grant, saturating count while the handshake is open.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (load_grant) begin
            tmo_cnt_d = '0;
        end else if (busy && (tmo_cnt_q != '1)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        tmo_set = busy && (tmo_cnt_d == '1);
    end

    // Counter and sticky flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_set) begin
                tmo_flag_q <= 1'b1;
            end else if (timeout_clr) begin
                tmo_flag_q <= 1'b0;
            end
        end
    end

    assign timeout_flag = tmo_flag_q;
`else
    logic unused_timeout_clr;
    assign unused_timeout_clr = timeout_clr;
    assign timeout_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter with a grant scoreboard.
// Build with INT_ARB_WATCHDOG_EN defined to exercise the watchdog.
module tb_interrupt_arbiter;

    localparam int N  = 4;
    localparam int CW = 9;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      src_req;
    logic [N*64-1:0]   src_obj;
    logic [N*CW-1:0]   src_ctx;
    logic [N-1:0]      src_ack;
    logic              int_req;
    logic [63:0]       int_obj;
    logic [CW-1:0]     int_ctx;
    logic              int_ack;
    logic              busy;
    logic              timeout_flag;
    logic              timeout_clr;

    typedef struct {
        int            idx;
        logic [63:0]   obj;
        logic [CW-1:0] ctx;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_int_req = 1'b0;

    interrupt_arbiter #(.NUM_SRC(N), .CTXW(CW), .TMO_W(TW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .src_req      (src_req),
        .src_obj      (src_obj),
        .src_ctx      (src_ctx),
        .src_ack      (src_ack),
        .int_req      (int_req),
        .int_obj      (int_obj),
        .int_ctx      (int_ctx),
        .int_ack      (int_ack),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .timeout_clr  (timeout_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and run the scoreboard on the DUT outputs.
    task automatic tick();
        @(negedge clk);
        if (int_req && !prev_int_req) begin
            check("grant_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check("grant_obj", int_obj, exp_q[0].obj);
                check("grant_ctx", 64'(int_ctx), 64'(exp_q[0].ctx));
            end
        end
        if (src_ack != '0) begin
            check("ack_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                check("src_ack", 64'(src_ack), 64'(4'b0001 << exp_q[0].idx));
                void'(exp_q.pop_front());
            end
        end
        prev_int_req = int_req;
    endtask

    task automatic raise(input int i, input logic [63:0] obj, input logic [CW-1:0] ctx);
        src_obj[i*64 +: 64] = obj;
        src_ctx[i*CW +: CW] = ctx;
        src_req[i]          = 1'b1;
    endtask

    task automatic expect_grant(input int i);
        exp_t e;
        e.idx = i;
        e.obj = src_obj[i*64 +: 64];
        e.ctx = src_ctx[i*CW +: CW];
        exp_q.push_back(e);
    endtask

    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!int_req && n < 50) begin
            tick();
            n++;
        end
        check(tag, 64'(int_req), 64'(1));
    endtask

    // Engine model: ack after 'delay' cycles, keep ack 'hold' extra cycles after int_req drops.
    task automatic engine(input int delay, input int drop, input int hold);
        repeat (delay) tick();
        int_ack = 1'b1;
        tick();
        check("req_cleared_on_ack", 64'(int_req), 64'(0));
        if (drop >= 0) src_req[drop] = 1'b0;
        repeat (hold) tick();
        int_ack = 1'b0;
        tick();
        check("idle_after_drain", 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        resetn      = 1'b0;
        src_req     = '0;
        src_obj     = '0;
        src_ctx     = '0;
        int_ack     = 1'b0;
        timeout_clr = 1'b0;
        repeat (3) tick();
        check("rst_int_req", 64'(int_req), 64'(0));
        check("rst_src_ack", 64'(src_ack), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_int_obj", int_obj, 64'(0));
        check("rst_int_ctx", 64'(int_ctx), 64'(0));
        check("rst_timeout", 64'(timeout_flag), 64'(0));
        resetn = 1'b1;
        tick();

        // Spurious ack while idle is ignored.
        int_ack = 1'b1;
        repeat (2) tick();
        check("spurious_busy", 64'(busy), 64'(0));
        check("spurious_src_ack", 64'(src_ack), 64'(0));
        int_ack = 1'b0;
        tick();

        // Single requester 2: one-cycle latency, frozen payload, one-cycle ack.
        raise(2, 64'h0000_0000_DEAD_BEEF, 9'd5);
        expect_grant(2);
        tick();
        check("req_latency", 64'(int_req), 64'(1));
        check("busy_in_req", 64'(busy), 64'(1));
        repeat (10) tick();
        check("req_held", 64'(int_req), 64'(1));
        check("obj_frozen", int_obj, 64'h0000_0000_DEAD_BEEF);
        int_ack = 1'b1;
        tick();
        check("single_ack_vec", 64'(src_ack), 64'(4'b0100));
        check("single_req_low", 64'(int_req), 64'(0));
        src_req[2] = 1'b0;
        int_ack    = 1'b0;
        tick();
        check("ack_one_cycle", 64'(src_ack), 64'(0));
        check("single_idle", 64'(busy), 64'(0));

        // rr_ptr is now 3: with 1 and 3 requesting, 3 goes first, then 1.
        raise(1, 64'h1111_0000_0000_0001, 9'd1);
        raise(3, 64'h3333_0000_0000_0003, 9'd3);
        expect_grant(3);
        expect_grant(1);
        wait_req("rr_first", n);
        engine(2, 3, 0);
        wait_req("rr_second", n);
        engine(2, 1, 0);

        // Ack held in DRAIN; requester 1 withdraws before grant, requester 3 wins.
        raise(0, 64'h0000_AAAA_0000_0000, 9'd100);
        expect_grant(0);
        wait_req("drain_grant", n);
        repeat (2) tick();
        int_ack = 1'b1;
        tick();
        src_req[0] = 1'b0;
        raise(1, 64'h1111_2222_3333_4444, 9'd17);
        tick();
        check("drain_busy", 64'(busy), 64'(1));
        raise(3, 64'h3333_4444_5555_6666, 9'd300);
        src_req[1] = 1'b0;
        repeat (3) tick();
        check("drain_no_req", 64'(int_req), 64'(0));
        check("drain_busy_held", 64'(busy), 64'(1));
        int_ack = 1'b0;
        expect_grant(3);
        tick();
        check("drain_exit_no_req", 64'(int_req), 64'(0));
        tick();
        check("regrant_two_cycles", 64'(int_req), 64'(1));
        engine(1, 3, 0);

        // All four persistent with a 3-cycle engine: order 0,1,2,3,0 and one idle cycle between grants.
        for (int i = 0; i < N; i++) raise(i, 64'hC0DE_0000_0000_0000 + 64'(i), CW'(i + 8));
        expect_grant(0);
        expect_grant(1);
        expect_grant(2);
        expect_grant(3);
        expect_grant(0);
        for (int g = 0; g < 5; g++) begin
            wait_req("all_grant", n);
            if (g > 0) check("busy_gap", 64'(n), 64'(1));
            engine(3, -1, 0);
        end
        src_req = '0;
        tick();
        check("all_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset during REQ (rr_ptr=1, grant 3); after reset the lowest index 0 wins.
        raise(0, 64'h0BAD_0000_0000_0000, 9'd20);
        raise(3, 64'h3BAD_0000_0000_0003, 9'd23);
        expect_grant(3);
        wait_req("pre_reset_grant", n);
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_int_req", 64'(int_req), 64'(0));
        check("mid_rst_src_ack", 64'(src_ack), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        prev_int_req = 1'b0;
        tick();
        resetn = 1'b1;
        expect_grant(0);
        wait_req("post_reset_grant", n);
        engine(1, 0, 0);
        expect_grant(3);
        wait_req("post_reset_second", n);
        engine(1, 3, 0);

        // Watchdog: stalled engine, rr_ptr=0, requester 2 only.
        raise(2, 64'h0000_0000_0000_0B0B, 9'd2);
        expect_grant(2);
        wait_req("wd_grant", n);
`ifdef INT_ARB_WATCHDOG_EN
        repeat (14) tick();
        check("wd_before_sat", 64'(timeout_flag), 64'(0));
        timeout_clr = 1'b1;
        tick();
        check("wd_set_wins", 64'(timeout_flag), 64'(1));
        timeout_clr = 1'b0;
        repeat (3) tick();
        check("wd_held", 64'(timeout_flag), 64'(1));
        engine(1, 2, 0);
        check("wd_sticky", 64'(timeout_flag), 64'(1));
        timeout_clr = 1'b1;
        tick();
        check("wd_clr", 64'(timeout_flag), 64'(0));
        timeout_clr = 1'b0;
`else
        repeat (20) tick();
        check("wd_absent", 64'(timeout_flag), 64'(0));
        engine(1, 2, 0);
`endif
        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Shares the single TLX interrupt engine among `NUM_SRC` action/context requesters. Each requester presents a level request with a 64-bit source object and a context ID. The block grants requesters in round-robin order and drives the engine's level `interrupt` / `interrupt_ack` handshake. It returns a one-cycle acknowledge pulse to the winning requester. It sits between the action wrappers and the interrupt engine, on the same `clk`/`resetn` domain.

## Interface
- `NUM_SRC`, 4, number of requesters (2..16).
- `CTXW`, 9, context ID width; must match the engine.
- `TMO_W`, 24, watchdog counter width.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `src_req`  in  NUM_SRC  per-requester interrupt request, level.
- `src_obj`  in  NUM_SRC*64  source objects; requester i occupies bits [64i+63:64i].
- `src_ctx`  in  NUM_SRC*CTXW  context IDs; requester i occupies bits [CTXW*i+CTXW-1:CTXW*i].
- `src_ack`  out  NUM_SRC  one-cycle completion pulse, one-hot.
- `int_req`  out  1  to engine `interrupt`.
- `int_obj`  out  64  to engine `interrupt_src`.
- `int_ctx`  out  CTXW  to engine `interrupt_ctx`.
- `int_ack`  in  1  from engine `interrupt_ack`.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_flag`  out  1  sticky watchdog flag.
- `timeout_clr`  in  1  clears `timeout_flag`.

## Operation
- State machine: IDLE, REQ, DRAIN.
- IDLE:
  - If any `src_req` bit is set, pick winner g = first set bit at or after `rr_ptr`, wrapping at NUM_SRC-1 to 0.
  - Register g, `src_obj[g]` and `src_ctx[g]`; set `int_req`=1; go to REQ.
- REQ:
  - Hold `int_req`=1 with `int_obj`/`int_ctx` frozen.
  - On `int_ack`=1: clear `int_req`, pulse `src_ack[g]`, set `rr_ptr` = (g+1) mod NUM_SRC, go to DRAIN.
- DRAIN:
  - Remain until `int_ack`=0, then go to IDLE.
  - The block does not re-arbitrate while the engine still asserts ack.
- Requester rules:
  - Hold `src_req`, `src_obj` and `src_ctx` stable from assertion until `src_ack`.
  - Drop `src_req` no later than the cycle after `src_ack`.
  - A requester may withdraw before it is granted. A withdrawal after grant is ignored; the interrupt still completes.
- Arbitration:
  - `rr_ptr` advances only on completion.
  - A single persistent requester is re-granted back-to-back.
  - With all requesters asserted, grant order is 0,1,2,3,0,...
- `int_req` is ANDed with nothing else; the engine's `interrupt_enable` gating stays in the engine.

## Timing
- All outputs reset to 0; `rr_ptr` resets to 0; state resets to IDLE.
- Request to `int_req`: 1 cycle (registered in IDLE).
- `int_ack` high in REQ: `int_req` low and `src_ack[g]` high on the next cycle.
- Minimum cycles from `int_ack` to the next grant: 2 (DRAIN exits the cycle after the engine drops ack, then IDLE arbitrates).
- `busy` is combinational from state.
- Reset mid-operation: `int_req` drops immediately and no `src_ack` is issued. The engine shares `resetn`, so no half-handshake persists.
- `int_ack` seen while in IDLE (spurious) is ignored.

## Configuration
- `INT_ARB_WATCHDOG_EN` defined:
  - A TMO_W-bit counter clears on entry to REQ and increments in REQ and DRAIN, saturating at all-ones.
  - Reaching all-ones sets `timeout_flag`.
  - `timeout_clr` clears the flag. If set and clear coincide, set wins.
  - The watchdog reports only; it never aborts the handshake.
- Undefined: counter absent, `timeout_flag` tied to 0, `timeout_clr` unused.

## Structure
- Shared package `interrupt_arb_pkg`:
  - state encodings (one-hot, 3 bits);
  - default NUM_SRC, CTXW and TMO_W constants;
  - 64-bit object width constant.
- Sub-module `int_rr_pick`: combinational rotate-priority picker. Takes `req` vector and `rr_ptr`; returns `valid` and binary index. Instantiated once.

## Test plan
- Single requester: `src_req[2]`=1, `src_obj[2]`=0x0000_0000_DEAD_BEEF, `ctx`=5. Expect `int_req`=1 next cycle with `int_obj`=0xDEADBEEF and `int_ctx`=5. Engine acks after 10 cycles; expect `src_ack`=4'b0100 for exactly 1 cycle; `rr_ptr`=3.
- All four requesting continuously with a 3-cycle engine ack: grant order 0,1,2,3,0; no `src_ack` overlap; `busy` never low between grants longer than 1 cycle.
- Ack held by the engine for 5 cycles after `int_req` drops: block stays in DRAIN; no new `int_req` until 2 cycles after ack falls.
- Requester 1 withdraws before grant while requester 3 asserts: requester 3 is granted; no ack to requester 1.
- `resetn` pulsed low during REQ: `int_req`, `src_ack` and `busy` read 0 immediately; first post-reset grant goes to the lowest active index.
- With `INT_ARB_WATCHDOG_EN` and TMO_W=4: no ack for 16 cycles sets `timeout_flag`. `timeout_clr` on the same cycle as set leaves the flag 1; `timeout_clr` later clears it.
